// File: rtl/serial_negate_pkg.sv
// Shared types for the serial negate engine: FSM states and word transform modes.
package serial_negate_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    INVERT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    NEG2 = 2'b01,
    NEG1 = 2'b10
  } mode_t;

  // The reserved encoding 11 behaves as PASS.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return NEG2;
      2'b10:   return NEG1;
      default: return PASS;
    endcase
  endfunction

endpackage

// File: rtl/serial_word_counter.sv
// Bit position counter for LSB-first serial words: start-of-word load, wrap at WIDTH-1,
// and first/last position flags for the bit being accepted this cycle.
module serial_word_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic load,
  output logic first,
  output logic last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] pos;

  // A start-of-word marker only counts when it comes with an accepted bit.
  assign pos   = (advance && load) ? '0 : cnt_reg;
  assign first = (pos == '0);
  assign last  = (pos == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (advance) begin
      cnt_reg <= last ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/serial_negate_engine.sv
// Serial PASS / two's / ones' complement engine with one-cycle latency and word flags.
// Build option: define SERIAL_NEGATE_OVF_EN to enable NEG2 overflow detection on out_ovf.
module serial_negate_engine
  import serial_negate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_sow,
  input  logic [1:0] in_mode,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_eow,
  output logic       out_zero,
  output logic       out_ovf
);

  logic   first;
  logic   last;
  state_t state_reg, state_next, cur_state;
  mode_t  mode_reg, mode_next, cur_mode;
  logic   bit_next;
  logic   zero_next;

  serial_word_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(in_valid),
    .load   (in_sow),
    .first  (first),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SEARCH;
      mode_reg  <= PASS;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
    end
  end

  // Bit 0 starts a fresh word: SEARCH state and a newly sampled mode apply to it directly.
  always_comb begin
    cur_state  = first ? SEARCH : state_reg;
    cur_mode   = first ? decode_mode(in_mode) : mode_reg;
    state_next = state_reg;
    mode_next  = mode_reg;
    bit_next   = in_bit;
    zero_next  = 1'b0;

    if (in_valid) begin
      state_next = (cur_state == INVERT || in_bit) ? INVERT : SEARCH;
      mode_next  = cur_mode;
    end

    case (cur_mode)
      NEG2:    bit_next = (cur_state == INVERT) ? ~in_bit : in_bit;
      NEG1:    bit_next = ~in_bit;
      default: bit_next = in_bit;
    endcase

    // SEARCH at the final position with a 0 input marks an all-zero word.
    zero_next = last && (cur_state == SEARCH) && !in_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_eow   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_bit   <= in_valid & bit_next;
      out_eow   <= in_valid & last;
      out_zero  <= in_valid & zero_next;
    end
  end

`ifdef SERIAL_NEGATE_OVF_EN
  logic ovf_reg;

  // Only -2^(WIDTH-1) reaches the sign bit still in SEARCH with a 1 arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= in_valid & last & (cur_mode == NEG2) & (cur_state == SEARCH) & in_bit;
    end
  end

  assign out_ovf = ovf_reg;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_negate_engine.sv
// Directed self-checking bench for serial_negate_engine at WIDTH=8.
module tb_serial_negate_engine;

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG2 = 2'b01;
  localparam logic [1:0] M_NEG1 = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

`ifdef SERIAL_NEGATE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_sow = 1'b0;
  logic [1:0] in_mode = 2'b00;
  logic       out_valid, out_bit, out_eow, out_zero, out_ovf;

  int checks = 0;
  int failures = 0;

  serial_negate_engine #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_sow   (in_sow),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_eow  (out_eow),
    .out_zero (out_zero),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; return 1 after the rising edge.
  task automatic step(input logic v, input logic b, input logic s, input logic [1:0] m);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    in_sow   = s;
    in_mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    step(1'b0, 1'b1, 1'b1, M_NEG1);
    check({tag, "_gap_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_gap_bit"}, {31'd0, out_bit}, 32'd0);
  endtask

  // Send one 8-bit word LSB first; mode m applies to bits 0..2, m_late afterwards.
  task automatic send_word(input string tag, input logic [7:0] w, input logic [1:0] m,
                           input logic [1:0] m_late, input logic sow, input int gap_after,
                           input int gap_len, input logic [7:0] exp_word,
                           input logic exp_zero, input logic exp_ovf);
    logic [7:0] got_word;
    got_word = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w[i], sow && (i == 0), (i < 3) ? m : m_late);
      check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_eow%0d", tag, i), {31'd0, out_eow}, {31'd0, (i == 7)});
      got_word[i] = out_bit;
      if (i == 7) begin
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
      end
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) idle_check(tag);
      end
    end
    check({tag, "_word"}, {24'd0, got_word}, {24'd0, exp_word});
    $display("word %s in=%02h out=%02h exp=%02h", tag, w, got_word, exp_word);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {28'd0, out_bit, out_eow, out_zero, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send_word("neg2_06", 8'h06, M_NEG2, M_NEG2, 1'b1, -1, 0, 8'hFA, 1'b0, 1'b0);
    send_word("neg2_00", 8'h00, M_NEG2, M_NEG2, 1'b0, -1, 0, 8'h00, 1'b1, 1'b0);
    send_word("neg2_80", 8'h80, M_NEG2, M_NEG2, 1'b0, -1, 0, 8'h80, 1'b0, OVF_ON);
    send_word("pass_a5", 8'hA5, M_PASS, M_NEG1, 1'b0, -1, 0, 8'hA5, 1'b0, 1'b0);
    send_word("neg1_a5", 8'hA5, M_NEG1, M_PASS, 1'b0, -1, 0, 8'h5A, 1'b0, 1'b0);
    send_word("neg1_00", 8'h00, M_NEG1, M_NEG2, 1'b0, -1, 0, 8'hFF, 1'b1, 1'b0);
    send_word("pass_80", 8'h80, M_PASS, M_NEG2, 1'b0, -1, 0, 8'h80, 1'b0, 1'b0);
    send_word("rsvd_3c", 8'h3C, M_RSVD, M_NEG2, 1'b0, -1, 0, 8'h3C, 1'b0, 1'b0);
    send_word("gap_06", 8'h06, M_NEG2, M_NEG2, 1'b0, 2, 3, 8'hFA, 1'b0, 1'b0);

    // Partial word abandoned by a start-of-word at bit 4
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, M_NEG2);
      check($sformatf("part_eow%0d", i), {31'd0, out_eow}, 32'd0);
    end
    send_word("sow_01", 8'h01, M_NEG2, M_NEG2, 1'b1, -1, 0, 8'hFF, 1'b0, 1'b0);

    // Reset asserted mid-word at bit 5
    for (int i = 0; i < 5; i++) step(1'b1, (i == 1 || i == 2), 1'b0, M_NEG2);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_flags", {28'd0, out_bit, out_eow, out_zero, out_ovf}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    send_word("post_rst", 8'h06, M_NEG2, M_NEG2, 1'b0, -1, 0, 8'hFA, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b1, M_PASS);
    check("final_idle", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
